// File: rtl/decoded_instruction_queue_if.sv
// Decoded micro-op bundle plus its valid flag, shared by the decoder->queue
// and queue->issue links. master drives the bundle, slave consumes it.
interface decoded_instruction_queue_if #(
    parameter int addressWidth            = 64,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int regAccessPatternSize    = 2,
    parameter int regSize                 = 5,
    parameter int immediateSize           = 16
);
    logic                               enable;
    logic [opcodeSize-1:0]              opcode;
    logic [addressWidth-1:0]            instructionAddress;
    logic [funcUnitCodeSize-1:0]        functionalUnitType;
    logic [instructionCounterWidth:0]   instMajId;
    logic [instMinIdWidth-1:0]          instMinId;
    logic                               is64Bit;
    logic [PidSize-1:0]                 instPid;
    logic [TidSize-1:0]                 instTid;
    logic [regAccessPatternSize-1:0]    op1rw;
    logic [regAccessPatternSize-1:0]    op2rw;
    logic                               op1isReg;
    logic                               op2isReg;
    logic                               immIsExtended;
    logic                               immIsShifted;
    logic [2*regSize+immediateSize-1:0] instructionBody;

    modport master (
        output enable, opcode, instructionAddress, functionalUnitType,
               instMajId, instMinId, is64Bit, instPid, instTid,
               op1rw, op2rw, op1isReg, op2isReg,
               immIsExtended, immIsShifted, instructionBody
    );

    modport slave (
        input enable, opcode, instructionAddress, functionalUnitType,
              instMajId, instMinId, is64Bit, instPid, instTid,
              op1rw, op2rw, op1isReg, op2isReg,
              immIsExtended, immIsShifted, instructionBody
    );
endinterface

// File: rtl/decoded_instruction_queue.sv
// In-order show-ahead FIFO of decoded micro-ops between decoder and issue.
// Ports: clock_i, reset_i (sync, active-high), flush_i, pop_i;
//   inQ  (slave)  decoder bundle, enable = push request;
//   outQ (master) head entry, enable = queue not empty;
//   stall_o (full), overflow_o (sticky dropped push), count_o (occupancy).
module decoded_instruction_queue #(
    parameter int QueueDepth              = 4,
    parameter int addressWidth            = 64,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int regAccessPatternSize    = 2,
    parameter int regSize                 = 5,
    parameter int immediateSize           = 16
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic                          pop_i,
    decoded_instruction_queue_if.slave    inQ,
    decoded_instruction_queue_if.master   outQ,
    output logic                          stall_o,
    output logic                          overflow_o,
    output logic [$clog2(QueueDepth):0]   count_o
);
    localparam int PtrW = $clog2(QueueDepth);
    localparam int CntW = PtrW + 1;
    localparam int BodyW = 2*regSize + immediateSize;

    typedef struct packed {
        logic [opcodeSize-1:0]             opcode;
        logic [addressWidth-1:0]           instructionAddress;
        logic [funcUnitCodeSize-1:0]       functionalUnitType;
        logic [instructionCounterWidth:0]  instMajId;
        logic [instMinIdWidth-1:0]         instMinId;
        logic                              is64Bit;
        logic [PidSize-1:0]                instPid;
        logic [TidSize-1:0]                instTid;
        logic [regAccessPatternSize-1:0]   op1rw;
        logic [regAccessPatternSize-1:0]   op2rw;
        logic                              op1isReg;
        logic                              op2isReg;
        logic                              immIsExtended;
        logic                              immIsShifted;
        logic [BodyW-1:0]                  instructionBody;
    } entry_t;

    entry_t         mem [QueueDepth];
    entry_t         inEntry;
    entry_t         headEntry;
    logic [PtrW-1:0] rdPtr;
    logic [PtrW-1:0] wrPtr;
    logic [CntW-1:0] count;
    logic           empty;
    logic           full;
    logic           popEff;
    logic           push;

    assign empty  = (count == '0);
    assign full   = (count == CntW'(QueueDepth));
    assign popEff = pop_i & ~empty;
    // A full queue still accepts a push when the head leaves this cycle.
    assign push   = inQ.enable & (~full | popEff);

    assign inEntry = '{
        opcode:             inQ.opcode,
        instructionAddress: inQ.instructionAddress,
        functionalUnitType: inQ.functionalUnitType,
        instMajId:          inQ.instMajId,
        instMinId:          inQ.instMinId,
        is64Bit:            inQ.is64Bit,
        instPid:            inQ.instPid,
        instTid:            inQ.instTid,
        op1rw:              inQ.op1rw,
        op2rw:              inQ.op2rw,
        op1isReg:           inQ.op1isReg,
        op2isReg:           inQ.op2isReg,
        immIsExtended:      inQ.immIsExtended,
        immIsShifted:       inQ.immIsShifted,
        instructionBody:    inQ.instructionBody
    };

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (popEff)
                rdPtr <= rdPtr + 1'b1;
            unique case ({push, popEff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (inQ.enable & full & ~popEff)
                overflow_o <= 1'b1;
        end
    end

    // Storage needs no reset; the head is masked while the queue is empty.
    always_ff @(posedge clock_i) begin
        if (!reset_i && !flush_i && push)
            mem[wrPtr] <= inEntry;
    end

    assign headEntry = empty ? '0 : mem[rdPtr];

    assign outQ.enable             = ~empty;
    assign outQ.opcode             = headEntry.opcode;
    assign outQ.instructionAddress = headEntry.instructionAddress;
    assign outQ.functionalUnitType = headEntry.functionalUnitType;
    assign outQ.instMajId          = headEntry.instMajId;
    assign outQ.instMinId          = headEntry.instMinId;
    assign outQ.is64Bit            = headEntry.is64Bit;
    assign outQ.instPid            = headEntry.instPid;
    assign outQ.instTid            = headEntry.instTid;
    assign outQ.op1rw              = headEntry.op1rw;
    assign outQ.op2rw              = headEntry.op2rw;
    assign outQ.op1isReg           = headEntry.op1isReg;
    assign outQ.op2isReg           = headEntry.op2isReg;
    assign outQ.immIsExtended      = headEntry.immIsExtended;
    assign outQ.immIsShifted       = headEntry.immIsShifted;
    assign outQ.instructionBody    = headEntry.instructionBody;

    assign stall_o = full;
    assign count_o = count;
endmodule

// File: tb/tb_decoded_instruction_queue.sv
// Directed scoreboard bench for decoded_instruction_queue.
// Expected heads come from a queue model updated as stimulus is applied.
module tb_decoded_instruction_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       pop = 1'b0;
    logic       stall;
    logic       ovf;
    logic [2:0] cnt;

    int nAsserts = 0;
    int nFails = 0;

    logic [64:0] sb [$];
    bit          ovfModel = 1'b0;

    decoded_instruction_queue_if inQ ();
    decoded_instruction_queue_if outQ ();

    decoded_instruction_queue dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .flush_i    (flush),
        .pop_i      (pop),
        .inQ        (inQ),
        .outQ       (outQ),
        .stall_o    (stall),
        .overflow_o (ovf),
        .count_o    (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] opOf(input logic [64:0] id);
        return id[11:0] ^ 12'hA5C;
    endfunction

    function automatic logic [63:0] addrOf(input logic [64:0] id);
        return {id[31:0], ~id[31:0]};
    endfunction

    function automatic logic [25:0] bodyOf(input logic [64:0] id);
        return id[25:0] ^ 26'h2AAAAAA;
    endfunction

    task automatic drive(input bit en, input logic [64:0] id);
        inQ.enable             = en;
        inQ.opcode             = opOf(id);
        inQ.instructionAddress = addrOf(id);
        inQ.functionalUnitType = id[2:0] ^ 3'h5;
        inQ.instMajId          = id;
        inQ.instMinId          = id[6:0];
        inQ.is64Bit            = id[0];
        inQ.instPid            = id[19:0] ^ 20'h12345;
        inQ.instTid            = id[15:0];
        inQ.op1rw              = id[1:0];
        inQ.op2rw              = ~id[1:0];
        inQ.op1isReg           = id[1];
        inQ.op2isReg           = ~id[1];
        inQ.immIsExtended      = id[2];
        inQ.immIsShifted       = id[3];
        inQ.instructionBody    = bodyOf(id);
    endtask

    task automatic chkState(input string tag);
        chk({tag, ".count"}, 128'(cnt), 128'(sb.size()));
        chk({tag, ".enable"}, 128'(outQ.enable), 128'(sb.size() != 0));
        chk({tag, ".stall"}, 128'(stall), 128'(sb.size() == 4));
        chk({tag, ".overflow"}, 128'(ovf), 128'(ovfModel));
    endtask

    task automatic step(input string tag, input bit en,
                        input logic [64:0] id, input bit pp, input bit fl);
        logic [64:0] exp;
        bit          popE;
        bit          acc;
        drive(en, id);
        pop   = pp;
        flush = fl;
        if (pp && !fl && sb.size() > 0) begin
            exp = sb[0];
            chk({tag, ".majId"}, 128'(outQ.instMajId), 128'(exp));
            chk({tag, ".opcode"}, 128'(outQ.opcode), 128'(opOf(exp)));
            chk({tag, ".addr"}, 128'(outQ.instructionAddress),
                128'(addrOf(exp)));
            chk({tag, ".body"}, 128'(outQ.instructionBody),
                128'(bodyOf(exp)));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            popE = pp && sb.size() > 0;
            acc  = en && (sb.size() < 4 || popE);
            if (en && sb.size() == 4 && !popE)
                ovfModel = 1'b1;
            if (popE)
                void'(sb.pop_front());
            if (acc)
                sb.push_back(id);
        end
        drive(1'b0, '0);
        pop   = 1'b0;
        flush = 1'b0;
        chkState(tag);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        ovfModel = 1'b0;
        chkState("reset");
    endtask

    task automatic fill(input string tag, input logic [64:0] base,
                        input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b1, base + 65'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        drive(1'b0, '0);

        doReset();
        chk("reset.majIdZero", 128'(outQ.instMajId), '0);
        chk("reset.opcodeZero", 128'(outQ.opcode), '0);
        chk("reset.addrZero", 128'(outQ.instructionAddress), '0);
        chk("reset.bodyZero", 128'(outQ.instructionBody), '0);

        fill("fill", 65'd1, 4);
        chk("fill.count4", 128'(cnt), 128'd4);
        chk("fill.stall", 128'(stall), 128'd1);
        drain("drain", 4);
        chk("drain.empty", 128'(outQ.enable), 128'd0);

        fill("fullpp.fill", 65'd1, 4);
        step("fullpp", 1'b1, 65'd5, 1'b1, 1'b0);
        chk("fullpp.head2", 128'(outQ.instMajId), 128'd2);
        drain("fullpp.drain", 4);

        fill("ovf.fill", 65'd1, 4);
        step("ovf.push9", 1'b1, 65'd9, 1'b0, 1'b0);
        chk("ovf.sticky", 128'(ovf), 128'd1);
        drain("ovf.drain", 4);
        step("ovf.idle", 1'b0, '0, 1'b0, 1'b0);
        doReset();

        fill("flush.fill", 65'd1, 3);
        step("flush", 1'b1, 65'd7, 1'b0, 1'b1);
        chk("flush.count0", 128'(cnt), 128'd0);
        step("flush.popEmpty", 1'b0, '0, 1'b1, 1'b0);
        step("flush.ppEmpty", 1'b1, 65'h20, 1'b1, 1'b0);
        drain("flush.drain", 1);

        fill("wrap.fill", 65'h10, 2);
        for (int i = 2; i < 10; i++)
            step("wrap.pp", 1'b1, 65'h10 + 65'(i), 1'b1, 1'b0);
        drain("wrap.drain", 2);

        fill("midreset.fill", 65'h30, 2);
        step("midreset.ppOne", 1'b1, 65'h32, 1'b1, 1'b0);
        doReset();
        chk("midreset.enable", 128'(outQ.enable), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFails);
        $finish;
    end
endmodule
